// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped 8N1 UART transmitter with a small byte FIFO.
//
// Register map (addr_i[3:2]):
//   0x0 CTRL   bit0 tx_en, bit1 int_en
//   0x4 STATUS bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky, W1C), bits 8:4 count
//   0x8 DIV    bits 15:0 clk cycles per bit (values below 2 stored as 2)
//   0xC TXDATA write pushes data_i[7:0]; reads as 0
//
// Ports:
//   clk     system clock, all logic on posedge
//   rst     synchronous active-high reset
//   we_i    write strobe
//   addr_i  register address (only bits 3:2 decoded)
//   data_i  write data
//   data_o  read data, combinational from addr_i
//   tx_pin  registered serial output, idle high
//   int_o   level interrupt: int_en & FIFO empty & transmitter idle
module uart_tx_fifo #(
  parameter int unsigned DEFAULT_DIV = 434,
  parameter int unsigned DEPTH       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_pin,
  output logic        int_o
);

  localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DepthCnt = 5'(DEPTH);
  localparam logic [15:0] ResetDiv = (DEFAULT_DIV < 2) ? 16'd2 : 16'(DEFAULT_DIV);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Register state
  logic            tx_en_q, int_en_q;
  logic [15:0]     div_q;
  logic            ovf_q;

  // FIFO state
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]      count_q, count_d;

  // Transmitter state
  state_e          state_q, state_d;
  logic [15:0]     div_cnt_q, div_cnt_d;
  logic [15:0]     bit_div_q, bit_div_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic [1:0]      reg_sel;
  logic            wr_ctrl, wr_status, wr_div, wr_txdata;
  logic            full, empty, busy;
  logic            push, pop, ovf_set, bit_done, start_ok;
  logic            unused_ok;

  assign unused_ok = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

  assign reg_sel   = addr_i[3:2];
  assign wr_ctrl   = we_i && (reg_sel == 2'd0);
  assign wr_status = we_i && (reg_sel == 2'd1);
  assign wr_div    = we_i && (reg_sel == 2'd2);
  assign wr_txdata = we_i && (reg_sel == 2'd3);

  assign full     = (count_q == DepthCnt);
  assign empty    = (count_q == 5'd0);
  assign busy     = (state_q != StIdle);
  assign start_ok = tx_en_q && !empty;

  // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
  assign push    = wr_txdata && (!full || pop);
  assign ovf_set = wr_txdata && full && !pop;

  // bit_div_q holds the divisor latched at the start of the current bit, so DIV
  // writes only take effect at the next bit boundary.
  assign bit_done = (div_cnt_q == bit_div_q - 16'd1);

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_div_d = bit_div_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    if (state_q != StIdle) begin
      if (bit_done) begin
        div_cnt_d = 16'd0;
        bit_div_d = div_q;
      end else begin
        div_cnt_d = div_cnt_q + 16'd1;
      end
    end

    // tx_d is the level for the bit that begins on this edge.
    unique case (state_q)
      StIdle: begin
        div_cnt_d = 16'd0;
        tx_d      = 1'b1;
        if (start_ok) begin
          pop       = 1'b1;
          state_d   = StStart;
          shift_d   = mem_q[rd_ptr_q];
          bit_div_d = div_q;
          tx_d      = 1'b0;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d   = StData;
          bit_cnt_d = 3'd0;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
        end
      end
      StData: begin
        if (bit_done) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      StStop: begin
        if (bit_done) begin
          if (start_ok) begin
            pop     = 1'b1;
            state_d = StStart;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 5'd1;
    end else if (!push && pop) begin
      count_d = count_q - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en_q   <= 1'b0;
      int_en_q  <= 1'b0;
      div_q     <= ResetDiv;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 5'd0;
      state_q   <= StIdle;
      div_cnt_q <= 16'd0;
      bit_div_q <= ResetDiv;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      if (wr_ctrl) begin
        tx_en_q  <= data_i[0];
        int_en_q <= data_i[1];
      end
      if (wr_div) begin
        div_q <= (data_i[15:0] < 16'd2) ? 16'd2 : data_i[15:0];
      end
      if (wr_status && data_i[3]) begin
        ovf_q <= 1'b0;
      end else if (ovf_set) begin
        ovf_q <= 1'b1;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q   <= count_d;
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_div_q <= bit_div_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i[7:0];
    end
  end

  always_comb begin
    data_o = 32'd0;
    unique case (reg_sel)
      2'd0: data_o = {30'd0, int_en_q, tx_en_q};
      2'd1: data_o = {23'd0, count_q, ovf_q, busy, empty, full};
      2'd2: data_o = {16'd0, div_q};
      2'd3: data_o = 32'd0;
    endcase
  end

  assign tx_pin = tx_q;
  assign int_o  = int_en_q && empty && !busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        tx_pin;
  logic        int_o;

  int tests = 0;
  int fails = 0;

  // Reference model: software queue of bytes not yet handed to the transmitter.
  logic [7:0] q [$];
  bit         ovf_m;
  int         div_m;
  bit         ie_m;

  uart_tx_fifo dut (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .tx_pin (tx_pin),
    .int_o  (int_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; data_i = d;
    @(posedge clk); #1;
    we_i = 1'b0; addr_i = 32'd0; data_i = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr_i = a;
    #1;
    d = data_o;
    addr_i = 32'd0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    if (q.size() < 8) q.push_back(b);
    else ovf_m = 1'b1;
    wr(32'hC, {24'd0, b});
  endtask

  function automatic logic [31:0] exp_status(input int n, input bit busy, input bit ovf);
    logic [4:0] n5;
    n5 = 5'(n);
    return {23'd0, n5, ovf, busy, (n == 0), (n == 8)};
  endfunction

  // Wait for a start bit, then compare every cycle of nbytes back-to-back frames.
  // Optionally writes CTRL=clear_val at cycle clear_at of the stream.
  task automatic stream(input int nbytes, input int clear_at, input logic [31:0] clear_val);
    logic [7:0] bytes_e [$];
    logic [7:0] b;
    logic       exp_bit;
    int         waited, total, frame, bitn;
    for (int k = 0; k < nbytes; k++) bytes_e.push_back(q.pop_front());
    waited = 0;
    @(negedge clk);
    while (tx_pin !== 1'b0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (tx_pin !== 1'b0) begin
      check("start bit timeout", {31'd0, tx_pin}, 32'd0);
      return;
    end
    total = nbytes * 10 * div_m;
    for (int i = 0; i < total; i++) begin
      frame = i / (10 * div_m);
      bitn  = (i / div_m) % 10;
      b     = bytes_e[frame];
      if (bitn == 0) exp_bit = 1'b0;
      else if (bitn == 9) exp_bit = 1'b1;
      else exp_bit = b[bitn-1];
      check($sformatf("tx frame%0d bit%0d cyc%0d", frame, bitn, i % div_m),
            {31'd0, tx_pin}, {31'd0, exp_bit});
      check("int_o while busy", {31'd0, int_o}, 32'd0);
      if (i == clear_at) begin
        we_i = 1'b1; addr_i = 32'd0; data_i = clear_val;
      end else if (i == clear_at + 1) begin
        we_i = 1'b0; addr_i = 32'd0; data_i = 32'd0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  dropped;
    int          n, waited;
    bit          ie;

    rst = 1'b1; we_i = 1'b0; addr_i = 32'd0; data_i = 32'd0;
    ovf_m = 1'b0; div_m = 434; ie_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset tx_pin", {31'd0, tx_pin}, 32'd1);
    check("reset int_o", {31'd0, int_o}, 32'd0);
    rd(32'h0, r); check("reset CTRL", r, 32'd0);
    rd(32'h4, r); check("reset STATUS", r, 32'h2);
    rd(32'h8, r); check("reset DIV", r, 32'd434);
    rd(32'hC, r); check("TXDATA reads 0", r, 32'd0);

    // DIV clamping and masking
    wr(32'h8, 32'd0);          rd(32'h8, r); check("DIV=0 clamps", r, 32'd2);
    wr(32'h8, 32'd1);          rd(32'h8, r); check("DIV=1 clamps", r, 32'd2);
    wr(32'h8, 32'hFFFF_0007);  rd(32'h8, r); check("DIV upper bits", r, 32'd7);

    // Single 0xA5 frame at DIV=4
    div_m = 4; wr(32'h8, 32'd4);
    push_byte(8'hA5);
    wr(32'h0, 32'd1);
    stream(1, -1, 32'd0);
    check("A5 idle tx_pin", {31'd0, tx_pin}, 32'd1);
    rd(32'h4, r); check("A5 done STATUS", r, exp_status(0, 0, 0));

    // Back-to-back 0x01, 0x02 with interrupt enabled
    wr(32'h0, 32'd2); ie_m = 1'b1;
    check("int_o empty idle", {31'd0, int_o}, 32'd1);
    push_byte(8'h01);
    check("int_o not empty", {31'd0, int_o}, 32'd0);
    push_byte(8'h02);
    wr(32'h0, 32'd3);
    stream(2, -1, 32'd0);
    check("int_o after drain", {31'd0, int_o}, 32'd1);
    rd(32'h0, r); check("CTRL readback", r, 32'd3);

    // Randomized rounds
    for (int rnd = 0; rnd < 4; rnd++) begin
      div_m = $urandom_range(2, 5);
      wr(32'h8, 32'(div_m));
      n  = $urandom_range(1, 4);
      ie = 1'($urandom_range(0, 1));
      ie_m = ie;
      wr(32'h0, {30'd0, ie, 1'b0});
      for (int k = 0; k < n; k++) push_byte(8'($urandom));
      rd(32'h4, r); check("rand queued STATUS", r, exp_status(q.size(), 0, ovf_m));
      wr(32'h0, {30'd0, ie, 1'b1});
      stream(n, -1, 32'd0);
      check("rand int_o", {31'd0, int_o}, {31'd0, ie_m});
      rd(32'h4, r); check("rand done STATUS", r, exp_status(0, 0, 0));
    end

    // Overflow: nine writes into an 8-deep FIFO with tx disabled
    div_m = 3; wr(32'h8, 32'd3);
    wr(32'h0, 32'd0); ie_m = 1'b0;
    for (int k = 0; k < 8; k++) push_byte(8'($urandom));
    dropped = 8'($urandom);
    push_byte(dropped);
    rd(32'h4, r); check("overflow STATUS", r, exp_status(8, 0, 1));
    wr(32'h4, 32'hFFFF_FFF7);
    rd(32'h4, r); check("STATUS read-only bits", r, exp_status(8, 0, 1));
    wr(32'h4, 32'h8); ovf_m = 1'b0;
    rd(32'h4, r); check("overflow cleared", r, exp_status(8, 0, 0));

    // Push on the same edge as the first pop while full
    wr(32'h0, 32'd1);
    wr(32'hC, {24'd0, ~dropped});
    q.push_back(~dropped);
    rd(32'h4, r); check("push+pop full STATUS", r, exp_status(q.size() - 1, 1, 0));
    stream(9, -1, 32'd0);
    rd(32'h4, r); check("full drain STATUS", r, exp_status(0, 0, 0));

    // Clearing tx_en mid-frame
    div_m = 2; wr(32'h8, 32'd0);
    rd(32'h8, r); check("DIV=0 reads 2", r, 32'd2);
    wr(32'h0, 32'd0);
    for (int k = 0; k < 3; k++) push_byte(8'($urandom));
    wr(32'h0, 32'd1);
    stream(1, 5, 32'd0);
    repeat (10) @(negedge clk);
    check("tx_en off idle tx_pin", {31'd0, tx_pin}, 32'd1);
    rd(32'h4, r); check("tx_en off STATUS", r, exp_status(q.size(), 0, 0));

    // Reset in the middle of a data bit
    wr(32'h0, 32'd1);
    waited = 0;
    @(negedge clk);
    while (tx_pin !== 1'b0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("pre-reset start bit", {31'd0, tx_pin}, 32'd0);
    repeat (div_m * 3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); div_m = 434;
    check("mid-frame reset tx_pin", {31'd0, tx_pin}, 32'd1);
    check("mid-frame reset int_o", {31'd0, int_o}, 32'd0);
    rd(32'h4, r); check("mid-frame reset STATUS", r, 32'h2);
    rd(32'h8, r); check("mid-frame reset DIV", r, 32'd434);
    rd(32'h0, r); check("mid-frame reset CTRL", r, 32'd0);
    repeat (30) @(negedge clk);
    check("post-reset tx_pin", {31'd0, tx_pin}, 32'd1);
    rd(32'h4, r); check("post-reset STATUS", r, 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
